// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC register, 1-cycle-latency imem requests, a DEPTH-entry
// prefetch queue with first-word fall-through, and branch redirect/flush.
module inst_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INST_W   = 32,
  parameter int unsigned          PC_STEP  = 4,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [INST_W-1:0]    NOP_INST = INST_W'(32'h1000_0000)
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [ADDR_W-1:0]           imem_addr,
  output logic                        imem_req,
  input  logic [INST_W-1:0]           imem_inst,
  input  logic                        branch_taken,
  input  logic [ADDR_W-1:0]           branch_target,
  input  logic                        stall,
  output logic [INST_W-1:0]           inst_out,
  output logic [ADDR_W-1:0]           inst_pc,
  output logic                        inst_valid,
  output logic [$clog2(DEPTH):0]      queue_count
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned CreditW = CntW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
  logic              tag_epoch_q, tag_epoch_d;
  logic              epoch_q, epoch_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

  logic [CreditW-1:0] credit_sum;
  logic               push;
  logic               pop;

  // Credit counts the in-flight request so a returning response always has a free slot.
  assign credit_sum = {1'b0, count_q} + CreditW'(inflight_q);
  assign imem_req   = reset & ~branch_taken & (credit_sum < CreditW'(DEPTH));
  assign imem_addr  = pc_q;

  // Responses from a previous flush epoch, or arriving during a flush, are dropped.
  assign push = inflight_q & ~branch_taken & (tag_epoch_q == epoch_q);
  assign pop  = inst_valid & ~stall & ~branch_taken;

  assign inst_valid  = (count_q != '0);
  assign inst_out    = inst_valid ? inst_mem_q[rd_ptr_q] : NOP_INST;
  assign inst_pc     = inst_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign queue_count = count_q;

  always_comb begin
    pc_d        = pc_q;
    inflight_d  = inflight_q;
    tag_pc_d    = tag_pc_q;
    tag_epoch_d = tag_epoch_q;
    epoch_d     = epoch_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (branch_taken) begin
      pc_d       = branch_target;
      inflight_d = 1'b0;
      epoch_d    = ~epoch_q;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = imem_req;
      if (imem_req) begin
        pc_d        = pc_q + ADDR_W'(PC_STEP);
        tag_pc_d    = pc_q;
        tag_epoch_d = epoch_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      tag_pc_q    <= '0;
      tag_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      tag_pc_q    <= tag_pc_d;
      tag_epoch_q <= tag_epoch_d;
      epoch_q     <= epoch_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= NOP_INST;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_inst;
      pc_mem_q[wr_ptr_q]   <= tag_pc_q;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    count_q <= CntW'(DEPTH));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a randomized run
// compared cycle by cycle against a queue-based reference model.
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP = 32'h1000_0000;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_inst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [2:0]  queue_count;

  logic        reset_w;
  logic [31:0] imem_addr_w;
  logic        imem_req_w;
  logic [31:0] imem_inst_w;
  logic        branch_taken_w;
  logic [31:0] branch_target_w;
  logic        stall_w;
  logic [31:0] inst_out_w;
  logic [31:0] inst_pc_w;
  logic        inst_valid_w;
  logic [2:0]  queue_count_w;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit u_dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_inst    (imem_inst),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .inst_out     (inst_out),
    .inst_pc      (inst_pc),
    .inst_valid   (inst_valid),
    .queue_count  (queue_count)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk          (clk),
    .reset        (reset_w),
    .imem_addr    (imem_addr_w),
    .imem_req     (imem_req_w),
    .imem_inst    (imem_inst_w),
    .branch_taken (branch_taken_w),
    .branch_target(branch_target_w),
    .stall        (stall_w),
    .inst_out     (inst_out_w),
    .inst_pc      (inst_pc_w),
    .inst_valid   (inst_valid_w),
    .queue_count  (queue_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: returns addr>>2 one cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    imem_inst   <= imem_req   ? (imem_addr >> 2)   : BAD;
    imem_inst_w <= imem_req_w ? (imem_addr_w >> 2) : BAD;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 of the first cycle out of reset.
  task automatic do_reset();
    reset        = 1'b0;
    branch_taken = 1'b0;
    stall        = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    next_cycle();
    next_cycle();
    checks++;
    if ({imem_req, imem_addr, inst_valid, inst_out, inst_pc, queue_count} !==
        {1'b0, 32'h0, 1'b0, NOP, 32'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%h valid=%b out=%h pc=%h cnt=%0d, want 0 0 0 %h 0 0",
               imem_req, imem_addr, inst_valid, inst_out, inst_pc, queue_count, NOP);
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_stream();
    logic        exp_v;
    logic [31:0] exp_pc, exp_out;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      #3;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_req k=%0d: req=%b addr=%h, want 1 %h", k, imem_req, imem_addr,
                 32'(4 * k));
      end
      exp_v   = (k >= 2);
      exp_pc  = exp_v ? 32'(4 * (k - 2)) : 32'h0;
      exp_out = exp_v ? 32'(k - 2) : NOP;
      checks++;
      if ({inst_valid, inst_pc, inst_out} !== {exp_v, exp_pc, exp_out}) begin
        errors++;
        $display("FAIL stream_out k=%0d: valid=%b pc=%h out=%h, want %b %h %h", k, inst_valid,
                 inst_pc, inst_out, exp_v, exp_pc, exp_out);
      end
    end
  endtask

  task automatic test_stall_fill();
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [2:0]  exp_cnt;
    do_reset();
    stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      #3;
      exp_req  = (k < 4);
      exp_addr = (k < 4) ? 32'(4 * k) : 32'h10;
      exp_cnt  = (k >= 2) ? 3'(k - 1) : 3'd0;
      checks++;
      if ({imem_req, imem_addr, queue_count} !== {exp_req, exp_addr, exp_cnt}) begin
        errors++;
        $display("FAIL stall_fill k=%0d: req=%b addr=%h cnt=%0d, want %b %h %0d", k, imem_req,
                 imem_addr, queue_count, exp_req, exp_addr, exp_cnt);
      end
    end
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      stall = 1'b0;
      #3;
      checks++;
      if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'(4 * i), 32'(i)}) begin
        errors++;
        $display("FAIL stall_drain i=%0d: valid=%b pc=%h out=%h, want 1 %h %h", i, inst_valid,
                 inst_pc, inst_out, 32'(4 * i), 32'(i));
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int k = 1; k <= 8; k++) next_cycle();
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    #3;
    checks++;
    if ({imem_req, imem_addr, inst_valid, inst_pc} !== {1'b0, 32'h20, 1'b1, 32'h18}) begin
      errors++;
      $display("FAIL branch_cycle: req=%b addr=%h valid=%b pc=%h, want 0 20 1 18", imem_req,
               imem_addr, inst_valid, inst_pc);
    end
    for (int d = 1; d <= 4; d++) begin
      next_cycle();
      branch_taken = 1'b0;
      #3;
      checks++;
      case (d)
        1, 2: if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'(32'h100 + 4 * (d - 1))})
          begin
            errors++;
            $display("FAIL branch_bubble d=%0d: valid=%b req=%b addr=%h, want 0 1 %h", d,
                     inst_valid, imem_req, imem_addr, 32'(32'h100 + 4 * (d - 1)));
          end
        default: if ({inst_valid, inst_pc, inst_out} !==
                     {1'b1, 32'(32'h100 + 4 * (d - 3)), 32'(32'h40 + d - 3)}) begin
            errors++;
            $display("FAIL branch_target d=%0d: valid=%b pc=%h out=%h, want 1 %h %h", d,
                     inst_valid, inst_pc, inst_out, 32'(32'h100 + 4 * (d - 3)),
                     32'(32'h40 + d - 3));
          end
      endcase
    end
  endtask

  task automatic test_branch_full();
    do_reset();
    stall = 1'b1;
    for (int k = 1; k <= 6; k++) next_cycle();
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    #3;
    checks++;
    if ({imem_req, queue_count, inst_pc} !== {1'b0, 3'd4, 32'h0}) begin
      errors++;
      $display("FAIL brfull_cycle: req=%b cnt=%0d pc=%h, want 0 4 0", imem_req, queue_count,
               inst_pc);
    end
    next_cycle();
    branch_taken = 1'b0;
    #3;
    checks++;
    if ({queue_count, inst_valid, imem_req, imem_addr} !== {3'd0, 1'b0, 1'b1, 32'h200}) begin
      errors++;
      $display("FAIL brfull_flush: cnt=%0d valid=%b req=%b addr=%h, want 0 0 1 200",
               queue_count, inst_valid, imem_req, imem_addr);
    end
    next_cycle();
    #3;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL brfull_b2: valid=%b, want 0", inst_valid);
    end
    next_cycle();
    #3;
    checks++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h200, 32'h80}) begin
      errors++;
      $display("FAIL brfull_b3: valid=%b pc=%h out=%h, want 1 200 80", inst_valid, inst_pc,
               inst_out);
    end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'hFFFF_FFF8;
    exp_seq[1] = 32'hFFFF_FFFC;
    exp_seq[2] = 32'h0;
    exp_seq[3] = 32'h4;
    reset_w = 1'b0;
    next_cycle();
    next_cycle();
    reset_w = 1'b1;
    #3;
    checks++;
    if ({imem_req_w, imem_addr_w} !== {1'b1, 32'hFFFF_FFF8}) begin
      errors++;
      $display("FAIL wrap_first_req: req=%b addr=%h, want 1 fffffff8", imem_req_w, imem_addr_w);
    end
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #3;
      checks++;
      if ({inst_valid_w, inst_pc_w} !== {1'b1, exp_seq[i]}) begin
        errors++;
        $display("FAIL wrap_seq i=%0d: valid=%b pc=%h, want 1 %h", i, inst_valid_w, inst_pc_w,
                 exp_seq[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    stall = 1'b1;
    for (int k = 1; k <= 4; k++) next_cycle();
    #3;
    checks++;
    if (queue_count !== 3'd3) begin
      errors++;
      $display("FAIL areset_fill: cnt=%0d, want 3", queue_count);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, inst_valid, inst_out, inst_pc, queue_count} !==
        {1'b0, 32'h0, 1'b0, NOP, 32'h0, 3'd0}) begin
      errors++;
      $display("FAIL areset_now: req=%b addr=%h valid=%b out=%h pc=%h cnt=%0d, want 0 0 0 %h 0 0",
               imem_req, imem_addr, inst_valid, inst_out, inst_pc, queue_count, NOP);
    end
    stall = 1'b0;
    next_cycle();
    reset = 1'b1;
    #3;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL areset_restart: req=%b addr=%h, want 1 0", imem_req, imem_addr);
    end
    next_cycle();
    next_cycle();
    #3;
    checks++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL areset_first: valid=%b pc=%h out=%h, want 1 0 0", inst_valid, inst_pc,
               inst_out);
    end
  endtask

  // Reference: an ordered list of fetched PCs, one optional outstanding request, a PC.
  task automatic test_random();
    logic [31:0] mq [$];
    logic        m_inf;
    logic [31:0] m_inf_pc;
    logic [31:0] m_pc;
    logic        e_req, e_valid;
    logic [31:0] e_pc, e_out;
    logic [2:0]  e_cnt;
    do_reset();
    mq.delete();
    m_inf    = 1'b0;
    m_inf_pc = 32'h0;
    m_pc     = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) next_cycle();
      stall         = ($urandom % 3) == 0;
      branch_taken  = ($urandom % 12) == 0;
      branch_target = $urandom & 32'hFFFF_FFFC;
      #3;
      e_valid = (mq.size() > 0);
      e_pc    = e_valid ? mq[0] : 32'h0;
      e_out   = e_valid ? (mq[0] >> 2) : NOP;
      e_cnt   = 3'(mq.size());
      e_req   = ((mq.size() + int'(m_inf)) < 4) && !branch_taken;
      checks++;
      if ({imem_req, imem_addr, inst_valid, inst_pc, inst_out, queue_count} !==
          {e_req, m_pc, e_valid, e_pc, e_out, e_cnt}) begin
        errors++;
        $display("FAIL random n=%0d: req=%b addr=%h valid=%b pc=%h out=%h cnt=%0d, want %b %h %b %h %h %0d",
                 n, imem_req, imem_addr, inst_valid, inst_pc, inst_out, queue_count,
                 e_req, m_pc, e_valid, e_pc, e_out, e_cnt);
      end
      if (branch_taken) begin
        mq.delete();
        m_inf = 1'b0;
        m_pc  = branch_target;
      end else begin
        if (e_valid && !stall) void'(mq.pop_front());
        if (m_inf) mq.push_back(m_inf_pc);
        m_inf = e_req;
        if (e_req) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
    branch_taken = 1'b0;
    stall        = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    branch_taken    = 1'b0;
    branch_target   = 32'h0;
    stall           = 1'b0;
    reset_w         = 1'b0;
    branch_taken_w  = 1'b0;
    branch_target_w = 32'h0;
    stall_w         = 1'b0;
    test_reset();
    test_stream();
    test_stall_fill();
    test_branch();
    test_branch_full();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Parametrised fetch front end for the pipelined processor. It replaces the fixed free-running PC and branch mux.
- Holds the PC and issues requests to instruction memory, which has a fixed 1-cycle latency.
- Buffers returned instructions in a DEPTH-entry prefetch queue and presents them to decode with a stall handshake.
- On a taken branch it flushes the queue, redirects the PC and discards in-flight stale responses. While no instruction is valid it drives a NOP encoding.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width.
- INST_W, 32, instruction width.
- PC_STEP, 4, PC increment per fetched instruction.
- DEPTH, 4, prefetch queue entries; power of 2, at least 2.
- RESET_PC, 0, PC value after reset.
- NOP_INST, 32'h10000000, encoding driven on inst_out when inst_valid=0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- imem_addr  output  ADDR_W  fetch address; equals the PC register.
- imem_req  output  1  fetch request this cycle.
- imem_inst  input  INST_W  instruction for the request issued in the previous cycle.
- branch_taken  input  1  redirect/flush strobe from decode.
- branch_target  input  ADDR_W  redirect address; sampled when branch_taken=1.
- stall  input  1  decode cannot accept; head is not popped.
- inst_out  output  INST_W  queue head, or NOP_INST when empty.
- inst_pc  output  ADDR_W  PC of inst_out; 0 when empty.
- inst_valid  output  1  queue non-empty.
- queue_count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (reset=0, async), all of the following:
  - pc=RESET_PC, queue empty, inflight=0.
  - imem_req=0, imem_addr=RESET_PC.
  - inst_valid=0, inst_out=NOP_INST, inst_pc=0, queue_count=0.
  - Reset mid-operation drops all queued and in-flight data immediately.
- Request issue: imem_req = (queue_count + inflight < DEPTH) & ~branch_taken, held 0 while reset=0.
  - inflight is a register set to 1 when imem_req was 1 in the prior cycle.
  - A pop in the same cycle does not free credit (conservative).
- On an imem_req edge: pc <= pc + PC_STEP (wraps modulo 2^ADDR_W); inflight <= 1. A per-request tag records the pc used.
- Response: in cycle N+1 after a request in cycle N, imem_inst and its tagged PC are written at the queue tail at the end of N+1. inst_valid first rises in N+2.
  - Request-to-inst_valid latency is 2 cycles.
- Output: inst_out/inst_pc are combinational from the head entry (first-word fall-through).
- Pop: when inst_valid=1 & stall=0 & branch_taken=0, the head advances at the clock edge.
  - Push and pop in the same cycle leave queue_count unchanged.
- Pointers wrap modulo DEPTH. Overflow is impossible by the credit rule; an assertion checks queue_count <= DEPTH.
- Flush (branch_taken=1 in cycle B):
  - The queue is cleared at the end of B; pc <= branch_target; no request is issued in B.
  - Any response arriving in B is discarded. A flush-epoch bit toggles, so any response tagged with the old epoch arriving in B+1 is also discarded.
  - First request to branch_target is issued in B+1; its instruction is valid in B+3.
  - inst_valid=0 in B+1 and B+2.
  - During B, outputs still show the old head, but no pop occurs.
- Simultaneous events:
  - branch_taken overrides stall, push and pop.
  - stall with a full queue holds all state.
  - branch_taken during reset=0 is ignored.
- pc and the queue never take X; no output depends combinationally on imem_inst, except through queue storage.

Test Plan:
- Reset release, stall=0, imem returns addr>>2: imem_addr 0,4,8,… on consecutive cycles → inst_valid rises 2 cycles after the first req; inst_pc 0,4,8 each cycle; inst_out=NOP_INST=32'h10000000 before that.
- Hold stall=1 from the start → queue_count reaches 4, imem_req drops to 0 with imem_addr=16; release stall → pops of 0,4,8,12 in order, then fetching resumes at 16 with no gap in inst_pc.
- Streaming at pc=0x20, branch_taken=1 with target=0x100 for one cycle → inst_valid=0 for 2 cycles; stale 0x20/0x24 data never appears; next inst_pc=0x100, then 0x104.
- branch_taken with stall=1 and a full queue → queue_count=0 next cycle; target instruction valid 3 cycles after the branch.
- RESET_PC=32'hFFFFFFF8, free-run → inst_pc sequence FFFFFFF8, FFFFFFFC, 0, 4 (wrap).
- Assert reset=0 asynchronously mid-stream with queue_count=3 → all outputs return to reset values within the same cycle; fetch restarts at RESET_PC after release.
